// File: rtl/snax_alu_csr_mc_pkg.sv
// Shared definitions for the SNAX ALU CSR manager.
// Holds the FSM state type, the CSR register indices and the bit positions
// inside the control (RW2) and status (RO0) registers.
package snax_alu_csr_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   // RW register indices
   localparam int unsigned RW_ALU_OP = 0;
   localparam int unsigned RW_LEN    = 1;
   localparam int unsigned RW_CTRL   = 2;

   // RO register indices
   localparam int unsigned RO_STATUS = 0;
   localparam int unsigned RO_PERF   = 1;
   localparam int unsigned RO_OUT    = 2;

   // control register bits (RW2)
   localparam int unsigned CTRL_START  = 0;
   localparam int unsigned CTRL_ABORT  = 1;
   localparam int unsigned CTRL_IRQ_EN = 2;

   // status register bits (RO0)
   localparam int unsigned STAT_BUSY    = 0;
   localparam int unsigned STAT_DONE    = 1;
   localparam int unsigned STAT_ABORTED = 2;

endpackage

// File: rtl/snax_alu_csr_mc_if.sv
// CSR bus between the host-side register master and the ALU CSR manager.
//   csr_reg_set_i       : RW register write data, one word per RW register
//   csr_reg_set_valid_i : write request
//   csr_reg_set_ready_o : write accept
//   csr_reg_ro_set_o    : RO register contents
// Signal names keep the manager's point of view (_i into it, _o out of it).
interface snax_alu_csr_mc_if #(
   parameter int unsigned RegRWCount   = 3,
   parameter int unsigned RegROCount   = 3,
   parameter int unsigned RegDataWidth = 32
);
   logic [RegRWCount-1:0][RegDataWidth-1:0] csr_reg_set_i;
   logic                                    csr_reg_set_valid_i;
   logic                                    csr_reg_set_ready_o;
   logic [RegROCount-1:0][RegDataWidth-1:0] csr_reg_ro_set_o;

   modport master (
      output csr_reg_set_i,
      output csr_reg_set_valid_i,
      input  csr_reg_set_ready_o,
      input  csr_reg_ro_set_o
   );

   modport slave (
      input  csr_reg_set_i,
      input  csr_reg_set_valid_i,
      output csr_reg_set_ready_o,
      output csr_reg_ro_set_o
   );
endinterface

// File: rtl/snax_alu_csr_mc_popcount.sv
// Counts how many PE output channels signalled a stored result this cycle.
//   bits_i  : per-channel strobe
//   count_o : number of set bits
module snax_alu_popcount #(
   parameter int unsigned NumChannels = 4
) (
   input  logic [NumChannels-1:0]           bits_i,
   output logic [$clog2(NumChannels+1)-1:0] count_o
);
   localparam int unsigned CntW = $clog2(NumChannels + 1);

   always_comb begin
      count_o = '0;
      for (int unsigned i = 0; i < NumChannels; i++) begin
         count_o = count_o + CntW'(bits_i[i]);
      end
   end
endmodule

// File: rtl/snax_alu_csr_mc.sv
// CSR manager for the SNAX ALU accelerator.
// Latches the op / length / control words on an accepted write, runs an
// IDLE/BUSY sequence that counts stored PE outputs until the programmed
// length is reached, and reports status, cycle count and output count.
//   clk_i, rst_ni         : clock, async active-low reset
//   csr_if                : CSR write channel and RO register readback
//   acc_output_success_i  : per-channel output-stored strobe
//   acc_ready_o           : PE may produce (high while BUSY)
//   csr_alu_config_o      : ALU operation
//   irq_o                 : one-cycle completion interrupt
//
// state   | meaning
// IDLE    | waiting for a start write; output strobes ignored
// BUSY    | counting stored outputs until length reached or aborted
module snax_alu_csr_mc
   import snax_alu_csr_pkg::*;
#(
   parameter int unsigned RegRWCount   = 3,
   parameter int unsigned RegROCount   = 3,
   parameter int unsigned RegDataWidth = 32,
   parameter int unsigned NumChannels  = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   snax_alu_csr_mc_if.slave       csr_if,
   input  logic [NumChannels-1:0] acc_output_success_i,
   output logic                   acc_ready_o,
   output logic [1:0]             csr_alu_config_o,
   output logic                   irq_o
);
   localparam int unsigned CntW = $clog2(NumChannels + 1);
   localparam int unsigned SumW = RegDataWidth + 1;

   state_e                  state_q, state_d;
   // Only the RW bits that carry meaning are stored.
   logic [1:0]              alu_op_q, alu_op_d;
   logic [RegDataWidth-1:0] len_q, len_d;
   logic                    irq_en_q, irq_en_d;
   logic [RegDataWidth-1:0] out_q, out_d;
   logic [RegDataWidth-1:0] perf_q, perf_d;
   logic                    done_q, done_d;
   logic                    aborted_q, aborted_d;
   logic                    irq_q, irq_d;

   logic [RegDataWidth-1:0] ctrl;
   logic                    busy, set_ready, accept, start_req, abort_req, finish;
   logic [CntW-1:0]         pop;
   logic [SumW-1:0]         sum;
   logic [RegROCount-1:0][RegDataWidth-1:0] ro_set;

   snax_alu_popcount #(.NumChannels(NumChannels)) i_popcount (
      .bits_i  (acc_output_success_i),
      .count_o (pop)
   );

   assign ctrl      = csr_if.csr_reg_set_i[RW_CTRL];
   assign busy      = (state_q == ST_BUSY);
   // Config stays locked while busy; only an abort request gets through.
   assign set_ready = !busy || ctrl[CTRL_ABORT];
   assign accept    = csr_if.csr_reg_set_valid_i && set_ready;
   assign start_req = accept && !busy && ctrl[CTRL_START];
   assign abort_req = accept && busy && ctrl[CTRL_ABORT];
   assign sum       = {1'b0, out_q} + SumW'(pop);
   assign finish    = busy && (sum >= {1'b0, len_q});

   always_comb begin
      state_d   = state_q;
      alu_op_d  = alu_op_q;
      len_d     = len_q;
      irq_en_d  = irq_en_q;
      out_d     = out_q;
      perf_d    = perf_q;
      done_d    = done_q;
      aborted_d = aborted_q;
      irq_d     = 1'b0;

      if (accept) begin
         alu_op_d = csr_if.csr_reg_set_i[RW_ALU_OP][1:0];
         len_d    = csr_if.csr_reg_set_i[RW_LEN];
         irq_en_d = ctrl[CTRL_IRQ_EN];
      end

      unique case (state_q)
         ST_IDLE: begin
            if (start_req) begin
               done_d    = 1'b0;
               aborted_d = 1'b0;
               out_d     = '0;
               perf_d    = '0;
               if (csr_if.csr_reg_set_i[RW_LEN] == '0) begin
                  done_d = 1'b1;
                  irq_d  = ctrl[CTRL_IRQ_EN];
               end else begin
                  state_d = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            perf_d = (&perf_q) ? perf_q : perf_q + 1'b1;
            // Finish takes priority over an abort in the same cycle.
            if (finish) begin
               out_d   = len_q;
               done_d  = 1'b1;
               irq_d   = irq_en_q;
               state_d = ST_IDLE;
            end else begin
               out_d = sum[RegDataWidth-1:0];
               if (abort_req) begin
                  aborted_d = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         alu_op_q  <= '0;
         len_q     <= '0;
         irq_en_q  <= 1'b0;
         out_q     <= '0;
         perf_q    <= '0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         alu_op_q  <= alu_op_d;
         len_q     <= len_d;
         irq_en_q  <= irq_en_d;
         out_q     <= out_d;
         perf_q    <= perf_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         irq_q     <= irq_d;
      end
   end

   always_comb begin
      ro_set                          = '0;
      ro_set[RO_STATUS][STAT_BUSY]    = busy;
      ro_set[RO_STATUS][STAT_DONE]    = done_q;
      ro_set[RO_STATUS][STAT_ABORTED] = aborted_q;
      ro_set[RO_PERF]                 = perf_q;
      ro_set[RO_OUT]                  = out_q;
   end

   assign csr_if.csr_reg_set_ready_o = set_ready;
   assign csr_if.csr_reg_ro_set_o    = ro_set;
   assign acc_ready_o                = busy;
   assign csr_alu_config_o           = alu_op_q;
   assign irq_o                      = irq_q;
endmodule

// File: tb/tb_snax_alu_csr_mc.sv
// Self-checking bench for snax_alu_csr_mc: directed scenarios plus random
// operations checked against a cumulative-count model of each operation.
module tb_snax_alu_csr_mc;
   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic [3:0] acc_output_success_i = '0;
   logic       acc_ready_o;
   logic [1:0] csr_alu_config_o;
   logic       irq_o;

   int n_checks = 0;
   int n_pass   = 0;
   int irq_cnt  = 0;

   snax_alu_csr_mc_if #(.RegRWCount(3), .RegROCount(3), .RegDataWidth(32)) csr_if ();

   snax_alu_csr_mc #(
      .RegRWCount(3), .RegROCount(3), .RegDataWidth(32), .NumChannels(4)
   ) dut (
      .clk_i                (clk_i),
      .rst_ni               (rst_ni),
      .csr_if               (csr_if),
      .acc_output_success_i (acc_output_success_i),
      .acc_ready_o          (acc_ready_o),
      .csr_alu_config_o     (csr_alu_config_o),
      .irq_o                (irq_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) if (irq_o) irq_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [31:0] status(input bit aborted, input bit done, input bit busy);
      return {29'd0, aborted, done, busy};
   endfunction

   task automatic drive_write(input logic [31:0] op, input logic [31:0] len, input logic [31:0] ctrl);
      csr_if.csr_reg_set_i[0]       = op;
      csr_if.csr_reg_set_i[1]       = len;
      csr_if.csr_reg_set_i[2]       = ctrl;
      csr_if.csr_reg_set_valid_i    = 1'b1;
   endtask

   task automatic csr_write(input logic [31:0] op, input logic [31:0] len, input logic [31:0] ctrl);
      drive_write(op, len, ctrl);
      step();
      csr_if.csr_reg_set_valid_i = 1'b0;
   endtask

   // Model: an operation ends in the first cycle whose cumulative strobe
   // count reaches len; out = min(total, len), perf = cycles spent busy.
   task automatic run_op(input logic [1:0] op, input int len, input bit irq_en,
                         input logic [3:0] seq[$]);
      int         total = 0;
      int         cyc   = 0;
      int         irq0;
      bit         fin   = 0;
      logic [3:0] s;
      irq0 = irq_cnt;
      check("start_ready", csr_if.csr_reg_set_ready_o, 1);
      csr_write({30'd0, op}, len, {29'd0, irq_en, 1'b0, 1'b1});
      check("alu_cfg", csr_alu_config_o, op);
      if (len == 0) begin
         check("zero_len_status", csr_if.csr_reg_ro_set_o[0], status(0, 1, 0));
         check("zero_len_acc_ready", acc_ready_o, 0);
         check("zero_len_irq", irq_o, irq_en);
      end else begin
         while (!fin && cyc < 200) begin
            s = (cyc < seq.size()) ? seq[cyc] : 4'($urandom);
            check("acc_ready_busy", acc_ready_o, 1);
            acc_output_success_i = s;
            step();
            total += $countones(s);
            cyc++;
            fin = (total >= len);
            check("ro_out", csr_if.csr_reg_ro_set_o[2], fin ? len : total);
            check("ro_perf", csr_if.csr_reg_ro_set_o[1], cyc);
            check("ro_status", csr_if.csr_reg_ro_set_o[0], status(0, fin, !fin));
         end
         acc_output_success_i = '0;
         check("finish_irq", irq_o, irq_en);
      end
      step();
      check("irq_drop", irq_o, 0);
      check("irq_pulses", irq_cnt - irq0, irq_en);
   endtask

   initial begin
      logic [3:0] q[$];
      logic [31:0] ro2_snap;
      int irq0;

      csr_if.csr_reg_set_i       = '0;
      csr_if.csr_reg_set_valid_i = 1'b0;
      #12;
      check("rst_ro0", csr_if.csr_reg_ro_set_o[0], 0);
      check("rst_ro1", csr_if.csr_reg_ro_set_o[1], 0);
      check("rst_ro2", csr_if.csr_reg_ro_set_o[2], 0);
      check("rst_acc_ready", acc_ready_o, 0);
      check("rst_set_ready", csr_if.csr_reg_set_ready_o, 1);
      check("rst_irq", irq_o, 0);
      check("rst_cfg", csr_alu_config_o, 0);
      rst_ni = 1'b1;
      step();

      q = {4'hF, 4'hF};
      run_op(2'd1, 8, 1, q);
      q = {4'hF, 4'h3};
      run_op(2'd2, 5, 1, q);
      q.delete();
      run_op(2'd3, 0, 1, q);
      run_op(2'd0, 0, 0, q);

      // strobes ignored while idle
      ro2_snap = csr_if.csr_reg_ro_set_o[2];
      acc_output_success_i = 4'hF;
      repeat (3) step();
      acc_output_success_i = '0;
      check("idle_ignore_out", csr_if.csr_reg_ro_set_o[2], ro2_snap);
      check("idle_ignore_status", csr_if.csr_reg_ro_set_o[0], status(0, 1, 0));

      for (int i = 0; i < 10; i++) begin
         q.delete();
         run_op(2'($urandom), $urandom_range(1, 40), 1'($urandom), q);
      end

      // locked config while busy, then abort
      irq0 = irq_cnt;
      csr_write(32'd1, 32'd100, 32'h5);
      acc_output_success_i = 4'h1;
      step();
      acc_output_success_i = '0;
      drive_write(32'd2, 32'd7, 32'h0);
      #1;
      check("locked_ready", csr_if.csr_reg_set_ready_o, 0);
      step();
      csr_if.csr_reg_set_valid_i = 1'b0;
      check("locked_cfg", csr_alu_config_o, 1);
      check("locked_busy", acc_ready_o, 1);
      drive_write(32'd3, 32'd7, 32'h2);
      #1;
      check("abort_ready", csr_if.csr_reg_set_ready_o, 1);
      step();
      csr_if.csr_reg_set_valid_i = 1'b0;
      check("abort_status", csr_if.csr_reg_ro_set_o[0], status(1, 0, 0));
      check("abort_acc_ready", acc_ready_o, 0);
      check("abort_out", csr_if.csr_reg_ro_set_o[2], 1);
      repeat (3) step();
      check("abort_no_irq", irq_cnt - irq0, 0);

      // abort in the same cycle as the final strobe: finish wins
      csr_write(32'd0, 32'd6, 32'h1);
      acc_output_success_i = 4'hF;
      step();
      acc_output_success_i = 4'h3;
      drive_write(32'd0, 32'd6, 32'h2);
      step();
      csr_if.csr_reg_set_valid_i = 1'b0;
      acc_output_success_i = '0;
      check("race_status", csr_if.csr_reg_ro_set_o[0], status(0, 1, 0));
      check("race_out", csr_if.csr_reg_ro_set_o[2], 6);

      // reset in the middle of an operation
      irq0 = irq_cnt;
      csr_write(32'd2, 32'd50, 32'h5);
      acc_output_success_i = 4'hF;
      repeat (3) step();
      rst_ni = 1'b0;
      #1;
      check("midrst_ro0", csr_if.csr_reg_ro_set_o[0], 0);
      check("midrst_ro1", csr_if.csr_reg_ro_set_o[1], 0);
      check("midrst_ro2", csr_if.csr_reg_ro_set_o[2], 0);
      check("midrst_acc_ready", acc_ready_o, 0);
      check("midrst_cfg", csr_alu_config_o, 0);
      #2;
      rst_ni = 1'b1;
      acc_output_success_i = '0;
      repeat (3) step();
      check("midrst_idle", csr_if.csr_reg_ro_set_o[0], 0);
      check("midrst_no_irq", irq_cnt - irq0, 0);

      q.delete();
      run_op(2'd1, 13, 1, q);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/snax_alu_csr_mc.md
SNAX_ALU_CSR_MC -- requirements
Module: snax_alu_csr_mc

Interface
REQ-001 SHALL have parameter RegRWCount, default 3, number of RW CSRs (minimum 3).
REQ-002 SHALL have parameter RegROCount, default 3, number of RO CSRs (minimum 3).
REQ-003 SHALL have parameter RegDataWidth, default 32, CSR width.
REQ-004 SHALL have parameter NumChannels, default 4, number of PE output channels (1..16).
REQ-005 SHALL have port clk_i, input, 1, clock; reset rst_ni, asynchronous, active-low; clock clk_i.
REQ-006 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port csr_reg_set_i, input, RegRWCount x RegDataWidth, RW register write data.
REQ-008 SHALL have port csr_reg_set_valid_i, input, 1, write request.
REQ-009 SHALL have port csr_reg_set_ready_o, output, 1, write accept.
REQ-010 SHALL have port csr_reg_ro_set_o, output, RegROCount x RegDataWidth, RO register contents.
REQ-011 SHALL have port acc_output_success_i, input, NumChannels, per-channel output-stored strobe.
REQ-012 SHALL have port acc_ready_o, output, 1, PE ready (high only in BUSY).
REQ-013 SHALL have port csr_alu_config_o, output, 2, ALU operation.
REQ-014 SHALL have port irq_o, output, 1, one-cycle completion interrupt.

Function
REQ-015 SHALL define RW0[1:0] as the ALU op, RW1 as the length in elements, RW2 bit0 as start, bit1 as abort, and bit2 as irq-enable; RW0/RW1/RW2 are latched only on an accepted write.
REQ-016 SHALL drive csr_reg_set_ready_o = !busy || csr_reg_set_i[2][1], so config is locked while BUSY except for abort requests.
REQ-017 SHALL implement FSM states IDLE and BUSY, entering BUSY when an accepted write has start=1 and length!=0.
REQ-018 SHALL, on an accepted write in IDLE with start=1 and length=0, stay in IDLE, set done, and pulse irq_o if irq-enable is set.
REQ-019 SHALL, each BUSY cycle, add popcount(acc_output_success_i) to out_count.
REQ-020 SHALL finish when out_count+popcount >= length; out_count then saturates at length.
REQ-021 SHALL, on finish, go BUSY->IDLE on the next edge, set done, and pulse irq_o one cycle later than the finishing strobe if irq-enable is set.
REQ-022 SHALL, on an accepted abort while BUSY, go to IDLE next edge, set aborted, leave done clear, and not raise irq.
REQ-023 SHALL let finish win when finish and abort occur in the same cycle: done is set and aborted is clear.
REQ-024 SHALL ignore acc_output_success_i while IDLE.
REQ-025 SHALL, on a start acceptance, clear done, aborted, out_count and perf_count.
REQ-026 SHALL increment perf_count each BUSY cycle, including the finishing cycle, saturating at all-ones.
REQ-027 SHALL map RO0 as {aborted(bit2), done(bit1), busy(bit0)}, RO1 as perf_count, RO2 as out_count, and zero any further RO registers.
REQ-028 SHALL drive acc_ready_o = busy and csr_alu_config_o = RW0[1:0] registered.

Reset
REQ-029 SHALL clear all RW registers, out_count, perf_count, done, aborted and irq_o on reset, with FSM=IDLE, acc_ready_o=0 and csr_reg_set_ready_o=1.
REQ-030 SHALL return to IDLE on a mid-operation reset with no irq pulse.

Structure
REQ-031 SHALL place the state enum, RW/RO register indices and control/status bit positions in package snax_alu_csr_pkg.
REQ-032 SHALL instantiate one sub-module, snax_alu_popcount, parametrised by NumChannels, with output width $clog2(NumChannels+1).

Verification
REQ-033 SHALL test: len=8, 4 channels, strobe 4'b1111 x2 -> busy 2 cycles, RO2=8, RO1=2, done=1, irq pulse 1 cycle.
REQ-034 SHALL test: len=5, strobe 4'b1111 then 4'b0011 -> finish on 2nd strobe, RO2=5 (saturated).
REQ-035 SHALL test: start len=0, irq-en=1 -> no BUSY, done=1, irq pulse.
REQ-036 SHALL test: write without abort while BUSY -> ready=0, config unchanged; write with abort -> IDLE, aborted=1, no irq.
REQ-037 SHALL test: abort in the same cycle as the final strobe -> done=1, aborted=0.
REQ-038 SHALL test: rst_ni low mid-BUSY -> all RO=0, acc_ready_o=0, FSM=IDLE.
